// File: rtl/emux_pkg.sv
// Shared definitions for the emux chain-bus transmitter: bus bit positions,
// FSM state encoding and the minimum padded payload size.
package emux_pkg;

  localparam int B_END    = 11;
  localparam int B_CLAIM  = 10;
  localparam int B_STROBE = 9;
  localparam int B_PORT   = 8;

  localparam int MIN_PAYLOAD = 18;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_HI,
    ST_HDR_LO,
`ifdef EMUX_TX_PAD_EN
    ST_PAYLOAD,
    ST_PAD
`else
    ST_PAYLOAD
`endif
  } state_e;

  function automatic logic [11:0] mk_word(input logic e, input logic c,
                                          input logic s, input logic p,
                                          input logic [7:0] d);
    return {e, c, s, p, d};
  endfunction

endpackage

// File: rtl/emux_tx.sv
// Chain-bus frame transmitter: passes in_c through when idle, otherwise claims
// the bus and emits a port header plus payload. EMUX_TX_PAD_EN pads short frames.
module emux_tx
  import emux_pkg::*;
#(
  parameter logic [15:0] PORT     = 16'h0000,
  parameter int          JUMBO_DW = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [11:0]         in_c,
  output logic [11:0]         out_c,
  input  logic                hold_in,
  output logic                hold_out,
  input  logic                tx_req,
  input  logic [JUMBO_DW-1:0] tx_len,
  input  logic [7:0]          tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic                tx_done
);

  state_e              state_q, state_d, phase;
  logic [11:0]         out_c_q, out_c_d;
  logic [JUMBO_DW-1:0] cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                start;
`ifdef EMUX_TX_PAD_EN
  logic [4:0]          pad_q, pad_d;
`endif

  // done_q blocks a restart on the END cycle so one pass-through cycle separates frames
  assign start    = tx_req & ~in_c[B_CLAIM] & ~hold_in & (state_q == ST_IDLE) & ~done_q;
  assign hold_out = hold_in | (state_q != ST_IDLE) | start;
  assign tx_ready = (state_q == ST_PAYLOAD);
  assign out_c    = out_c_q;
  assign tx_done  = done_q;

  // The start cycle itself produces the HDR_HI word so it is on out_c one cycle later
  always_comb phase = start ? ST_HDR_HI : state_q;

  always_comb begin
    state_d = state_q;
    out_c_d = in_c;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef EMUX_TX_PAD_EN
    pad_d   = pad_q;
`endif
    case (phase)
      ST_IDLE: out_c_d = in_c;
      ST_HDR_HI: begin
        out_c_d = mk_word(1'b0, 1'b1, 1'b0, 1'b0, PORT[15:8]);
        cnt_d   = tx_len;
        state_d = ST_HDR_LO;
`ifdef EMUX_TX_PAD_EN
        if (int'(tx_len) < MIN_PAYLOAD) pad_d = 5'(MIN_PAYLOAD - int'(tx_len));
        else                            pad_d = '0;
`endif
      end
      ST_HDR_LO: begin
        out_c_d = mk_word(cnt_q == '0, 1'b1, 1'b0, 1'b1, PORT[7:0]);
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (tx_valid) begin
          cnt_d = cnt_q - JUMBO_DW'(1);
          if (cnt_q == JUMBO_DW'(1)) begin
`ifdef EMUX_TX_PAD_EN
            if (pad_q != '0) begin
              state_d = ST_PAD;
            end else begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
`else
            state_d = ST_IDLE;
            done_d  = 1'b1;
`endif
          end
          out_c_d = mk_word(done_d, 1'b1, 1'b1, 1'b0, tx_data);
        end else begin
          out_c_d = mk_word(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        end
      end
`ifdef EMUX_TX_PAD_EN
      ST_PAD: begin
        out_c_d = mk_word(pad_q == 5'd1, 1'b1, 1'b1, 1'b0, 8'h00);
        pad_d   = pad_q - 5'd1;
        if (pad_q == 5'd1) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      out_c_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
`ifdef EMUX_TX_PAD_EN
      pad_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      out_c_q <= out_c_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
`ifdef EMUX_TX_PAD_EN
      pad_q   <= pad_d;
`endif
    end
  end

endmodule

// File: tb/tb_emux_tx.sv
// Directed bench for emux_tx with PORT=16'h1234; the padding scenario is built
// only when EMUX_TX_PAD_EN is defined.
module tb_emux_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] in_c;
  logic [11:0] out_c;
  logic        hold_in;
  logic        hold_out;
  logic        tx_req;
  logic [13:0] tx_len;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_done;

  int n_vec = 0;
  int n_bad = 0;

  emux_tx #(.PORT(16'h1234), .JUMBO_DW(14)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_c     (in_c),
    .out_c    (out_c),
    .hold_in  (hold_in),
    .hold_out (hold_out),
    .tx_req   (tx_req),
    .tx_len   (tx_len),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%03h, want 0x%03h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_c     = 12'h000;
    hold_in  = 1'b0;
    tx_req   = 1'b0;
    tx_len   = 14'd0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    tick();
    tick();
    chk("rst_out", out_c, 12'h000);
    chk("rst_done", 12'(tx_done), 12'h0);
    chk("rst_ready", 12'(tx_ready), 12'h0);

`ifdef EMUX_TX_PAD_EN
    // tx_len=2 padded out to 18 bytes
    rst_n = 1'b1; tx_req = 1'b1; tx_len = 14'd2; tx_valid = 1'b1; tx_data = 8'h11;
    tick(); chk("pad_hdr_hi", out_c, 12'h412);
    tick(); chk("pad_hdr_lo", out_c, 12'h534);
    tick(); chk("pad_d0", out_c, 12'h611); tx_data = 8'h22;
    tick(); chk("pad_d1", out_c, 12'h622); chk("pad_d1_done", 12'(tx_done), 12'h0);
    tx_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("pad_byte", out_c, 12'h600);
      chk("pad_ready", 12'(tx_ready), 12'h0);
      chk("pad_nodone", 12'(tx_done), 12'h0);
    end
    tick(); chk("pad_end", out_c, 12'hE00); chk("pad_done", 12'(tx_done), 12'h1);
    tx_req = 1'b0;
    tick(); chk("pad_after", out_c, 12'h000); chk("pad_after_done", 12'(tx_done), 12'h0);
`else
    // Basic 3-byte frame
    rst_n = 1'b1; tx_req = 1'b1; tx_len = 14'd3; tx_valid = 1'b1; tx_data = 8'hAA;
    #1 chk("f1_start_hold", 12'(hold_out), 12'h1);
    tick(); chk("f1_hdr_hi", out_c, 12'h412); chk("f1_ready_hi", 12'(tx_ready), 12'h0);
    tick(); chk("f1_hdr_lo", out_c, 12'h534); chk("f1_ready_pl", 12'(tx_ready), 12'h1);
    tick(); chk("f1_b0", out_c, 12'h6AA); tx_data = 8'hBB;
    tick(); chk("f1_b1", out_c, 12'h6BB); tx_data = 8'hCC;
    tick(); chk("f1_end", out_c, 12'hECC); chk("f1_done", 12'(tx_done), 12'h1);
    chk("f1_end_nohold", 12'(hold_out), 12'h0);
    // tx_req stays high: a pass-through cycle must precede the next frame (tx_len=0)
    tx_len = 14'd0; tx_valid = 1'b0; in_c = 12'h0A5;
    tick(); chk("gap_pass", out_c, 12'h0A5); chk("gap_done", 12'(tx_done), 12'h0);
    #1 chk("f0_start_hold", 12'(hold_out), 12'h1);
    tick(); chk("f0_hdr_hi", out_c, 12'h412); chk("f0_ready", 12'(tx_ready), 12'h0);
    tick(); chk("f0_end", out_c, 12'hD34); chk("f0_done", 12'(tx_done), 12'h1);
    chk("f0_ready_end", 12'(tx_ready), 12'h0);
    tx_req = 1'b0;
    tick(); chk("f0_pass", out_c, 12'h0A5); chk("f0_done_lo", 12'(tx_done), 12'h0);

    // Upstream frame holds off the request until CLAIM drops
    in_c = 12'h455; tx_req = 1'b1; tx_len = 14'd1; tx_valid = 1'b1; tx_data = 8'h5A;
    #1 chk("up_hold0", 12'(hold_out), 12'h0);
    tick(); chk("up_pass0", out_c, 12'h455);
    in_c = 12'hE77;
    #1 chk("up_hold1", 12'(hold_out), 12'h0);
    tick(); chk("up_pass1", out_c, 12'hE77);
    in_c = 12'h000;
    #1 chk("up_start", 12'(hold_out), 12'h1);
    tick(); chk("up_hdr_hi", out_c, 12'h412); in_c = 12'hFFF;
    tick(); chk("up_hdr_lo", out_c, 12'h534);
    tick(); chk("up_end", out_c, 12'hE5A); chk("up_done", 12'(tx_done), 12'h1);
    tx_req = 1'b0; in_c = 12'h000;
    tick(); chk("up_after", out_c, 12'h000);

    // hold_in blocks start; then a payload with a 3-cycle bubble gap
    hold_in = 1'b1; tx_req = 1'b1; tx_len = 14'd2; tx_valid = 1'b0;
    #1 chk("hi_hold", 12'(hold_out), 12'h1);
    tick(); chk("hi_nostart", out_c, 12'h000);
    hold_in = 1'b0;
    #1 chk("hi_start", 12'(hold_out), 12'h1);
    tick(); chk("hi_hdr_hi", out_c, 12'h412);
    tick(); chk("hi_hdr_lo", out_c, 12'h534);
    tx_valid = 1'b1; tx_data = 8'h11;
    tick(); chk("gap_b0", out_c, 12'h611);
    tx_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("gap_bubble", out_c, 12'h400);
      chk("gap_ready", 12'(tx_ready), 12'h1);
    end
    tx_valid = 1'b1; tx_data = 8'h22;
    tick(); chk("gap_end", out_c, 12'hE22); chk("gap_end_done", 12'(tx_done), 12'h1);
    tx_req = 1'b0; tx_valid = 1'b0;

    // Reset in the middle of a payload aborts without END or tx_done
    tick();
    tx_req = 1'b1; tx_len = 14'd3; tx_valid = 1'b1; tx_data = 8'h77;
    tick(); chk("ab_hdr_hi", out_c, 12'h412);
    tick(); chk("ab_hdr_lo", out_c, 12'h534);
    tick(); chk("ab_b0", out_c, 12'h677);
    rst_n = 1'b0; tx_req = 1'b0; tx_valid = 1'b0;
    tick(); chk("ab_out", out_c, 12'h000); chk("ab_done", 12'(tx_done), 12'h0);
    chk("ab_ready", 12'(tx_ready), 12'h0);
    rst_n = 1'b1; in_c = 12'h123;
    tick(); chk("ab_pass", out_c, 12'h123); chk("ab_done2", 12'(tx_done), 12'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
